// File: rtl/misty1_cbc_seq.sv
// rtl/misty1_cbc_seq.sv - block sequencer feeding a MISTY1 one-round-per-clock core
//
// Loads the 128-bit key into the core and waits for its key schedule. It then
// passes 64-bit blocks through the core one at a time and buffers each result
// for a valid/ready consumer.
// With MISTY1_SEQ_CBC_EN defined, blocks are CBC chained for both encrypt and
// decrypt. Without it the sequencer runs plain ECB, and the chain register and
// the IV path do not exist.
//
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   key_in, key_load                 cipher key and load request (IDLE only)
//   iv_in, iv_load                   initial chaining value and load request (IDLE only)
//   key_ok, err                      key schedule complete, sticky watchdog error
//   s_valid, s_ready, s_data, s_dec  input block stream; s_dec=1 selects decrypt
//   m_valid, m_ready, m_data         one-entry output block buffer
//   core_Din, core_Kin, core_Drdy, core_Krdy, core_EncDec   to the core
//   core_Dout, core_Dvld, core_Kvld                         from the core

module misty1_cbc_seq #(
    parameter int WDOG_CYCLES = 64,
    parameter int WDOG_W      = 7
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [63:0]  iv_in,
    input  logic         iv_load,
    output logic         key_ok,
    output logic         err,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [63:0]  s_data,
    input  logic         s_dec,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [63:0]  m_data,
    output logic [63:0]  core_Din,
    output logic [127:0] core_Kin,
    output logic         core_Drdy,
    output logic         core_Krdy,
    output logic         core_EncDec,
    input  logic [63:0]  core_Dout,
    input  logic         core_Dvld,
    input  logic         core_Kvld
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_WAIT,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    state_t              state_q, state_d;
    logic [127:0]        kin_q, kin_d;
    logic                krdy_q, krdy_d;
    logic                key_ok_q, key_ok_d;
    logic                err_q, err_d;
    logic [63:0]         din_q, din_d;
    logic                dec_q, dec_d;
    logic [63:0]         m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                wdog_expired;
    logic                accept;

`ifdef MISTY1_SEQ_CBC_EN
    logic [63:0]         chain_q, chain_d;
    logic [63:0]         snap_q, snap_d;   // chain value seen by the block in flight
    logic [63:0]         ct_q, ct_d;       // ciphertext of the block in flight (decrypt)
`else
    logic                unused_iv;
    assign unused_iv = ^{iv_load, iv_in};
`endif

    assign wdog_expired = (wdog_q == WDOG_LAST);
    // key_load wins over an input block offered in the same cycle
    assign accept       = (state_q == S_IDLE) & key_ok_q & ~key_load & s_valid;

    always_comb begin
        state_d   = state_q;
        kin_d     = kin_q;
        krdy_d    = 1'b0;
        key_ok_d  = key_ok_q;
        err_d     = err_q;
        din_d     = din_q;
        dec_d     = dec_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        wdog_d    = wdog_q;
        s_ready   = 1'b0;
`ifdef MISTY1_SEQ_CBC_EN
        chain_d   = chain_q;
        snap_d    = snap_q;
        ct_d      = ct_q;
`endif

        case (state_q)
            S_IDLE: begin
                s_ready = key_ok_q & ~key_load;
`ifdef MISTY1_SEQ_CBC_EN
                if (iv_load) begin
                    chain_d = iv_in;
                end
`endif
                if (key_load) begin
                    kin_d    = key_in;
                    krdy_d   = 1'b1;
                    key_ok_d = 1'b0;
                    err_d    = 1'b0;
                    wdog_d   = '0;
                    state_d  = S_KEY_WAIT;
                end else if (accept) begin
                    dec_d   = s_dec;
`ifdef MISTY1_SEQ_CBC_EN
                    snap_d  = chain_q;
                    ct_d    = s_data;
                    din_d   = s_dec ? s_data : (s_data ^ chain_q);
`else
                    din_d   = s_data;
`endif
                    state_d = S_ISSUE;
                end
            end

            S_KEY_WAIT: begin
                if (core_Kvld) begin
                    key_ok_d = 1'b1;
                    state_d  = S_IDLE;
                end else if (wdog_expired) begin
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wdog_d   = wdog_q + 1'b1;
                end
            end

            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (core_Dvld) begin
`ifdef MISTY1_SEQ_CBC_EN
                    if (dec_q) begin
                        m_data_d = core_Dout ^ snap_q;
                        chain_d  = ct_q;
                    end else begin
                        m_data_d = core_Dout;
                        chain_d  = core_Dout;
                    end
`else
                    m_data_d  = core_Dout;
`endif
                    m_valid_d = 1'b1;
                    state_d   = S_OUT;
                end else if (wdog_expired) begin
                    // a timed-out block leaves no output and no chain update
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
            end

            S_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            kin_q     <= '0;
            krdy_q    <= 1'b0;
            key_ok_q  <= 1'b0;
            err_q     <= 1'b0;
            din_q     <= '0;
            dec_q     <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            wdog_q    <= '0;
`ifdef MISTY1_SEQ_CBC_EN
            chain_q   <= '0;
            snap_q    <= '0;
            ct_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            kin_q     <= kin_d;
            krdy_q    <= krdy_d;
            key_ok_q  <= key_ok_d;
            err_q     <= err_d;
            din_q     <= din_d;
            dec_q     <= dec_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            wdog_q    <= wdog_d;
`ifdef MISTY1_SEQ_CBC_EN
            chain_q   <= chain_d;
            snap_q    <= snap_d;
            ct_q      <= ct_d;
`endif
        end
    end

    assign key_ok      = key_ok_q;
    assign err         = err_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign core_Din    = din_q;
    assign core_Kin    = kin_q;
    assign core_Krdy   = krdy_q;
    assign core_Drdy   = (state_q == S_ISSUE);
    assign core_EncDec = dec_q;

endmodule
